sram_streamer: RTL and testbench
================================

SRAM_STREAMER -- requirements
Module: sram_streamer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, word width of the SRAM and of the output stream.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 10, SRAM address width.
REQ-003 The block SHALL have parameter LEN_WIDTH, default 11, burst length width (up to 1024 words).
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port start, input, 1, burst request, sampled only in IDLE.
REQ-007 The block SHALL have port base_addr, input, ADDR_WIDTH, first word address, sampled with start.
REQ-008 The block SHALL have port length, input, LEN_WIDTH, number of words, sampled with start.
REQ-009 The block SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-010 The block SHALL have port done, output, 1, one-cycle completion pulse.
REQ-011 The block SHALL have port sram_we, output, 1, tied to constant 0 (read-only master).
REQ-012 The block SHALL have port sram_addr, output, ADDR_WIDTH, registered SRAM read address.
REQ-013 The block SHALL have port sram_dout, input, DATA_WIDTH, SRAM read data, valid one cycle after sram_addr is presented.
REQ-014 The block SHALL have port m_data, output, DATA_WIDTH, stream data.
REQ-015 The block SHALL have port m_valid, output, 1, stream valid.
REQ-016 The block SHALL have port m_ready, input, 1, stream ready; a beat transfers on a clock edge with m_valid and m_ready both high.

Function
REQ-017 The block SHALL implement the states IDLE, RUN and DRAIN.
REQ-018 IDLE SHALL go to RUN on start with length>0, latching base_addr and length.
REQ-019 IDLE SHALL raise done in the following cycle on start with length==0, produce no beats, and remain in IDLE.
REQ-020 RUN SHALL issue one read per cycle: sram_addr is set to the next address and the issued count is incremented, provided that (buffered + pending − pop) < 2.
  - pending: a read issued in the previous cycle.
  - pop: a handshake in the current cycle.
REQ-021 Read addresses SHALL increment by the stride and wrap modulo 2^ADDR_WIDTH.
REQ-022 The block SHALL capture sram_dout into a 2-entry FIFO on the edge following each issue cycle, and only then (the SRAM drives dout every cycle).
REQ-023 m_valid SHALL equal "FIFO not empty", and m_data SHALL equal the FIFO head.
REQ-024 m_data SHALL be held stable while m_valid is high and m_ready is low.
REQ-025 The first m_valid SHALL rise 2 cycles after the start edge.
REQ-026 With m_ready held high, the block SHALL sustain 1 beat per cycle.
REQ-027 RUN SHALL go to DRAIN once all length reads are issued.
REQ-028 DRAIN SHALL go to IDLE on the edge of the final handshake, with done high for the next cycle only.
REQ-029 start SHALL be ignored while busy.
REQ-030 A start during the done cycle SHALL be accepted, because the state is IDLE.
REQ-031 The FIFO SHALL never overflow; a capture and a pop in the same cycle SHALL leave the count unchanged.
REQ-032 Beats SHALL be emitted strictly in address order, exactly length beats per burst.

Reset
REQ-033 Asserting rst_n low SHALL immediately force state IDLE, busy=0, done=0, m_valid=0, FIFO empty, pending=0, sram_addr=0 and m_data=0.
REQ-034 Reset mid-burst SHALL discard all in-flight data; after release no stale beat SHALL appear and a new start SHALL behave normally.

Configuration
REQ-035 Macro SRAM_STREAMER_STRIDE_EN defined SHALL add input port stride (ADDR_WIDTH), sampled with start.
  - Addresses SHALL be base_addr + i*stride modulo 2^ADDR_WIDTH.
  - stride=0 SHALL repeat base_addr length times.
REQ-036 Macro SRAM_STREAMER_STRIDE_EN undefined SHALL omit the stride port and use a fixed stride of 1.

Verification
REQ-037 SRAM mem[i]=i, base=0x010, length=4, m_ready=1 -> beats 0x10,0x11,0x12,0x13 on consecutive cycles, first 2 cycles after start; done pulses once after the last beat.
REQ-038 Base=0x3FE, length=4 -> addresses 0x3FE,0x3FF,0x000,0x001; beats FE,FF,00,01.
REQ-039 Length=8 with m_ready toggling 1,0,0,1,... -> all 8 beats in order, none lost or duplicated, m_data stable while stalled, FIFO never exceeds 2.
REQ-040 Length=0 -> no m_valid; done high exactly 1 cycle after start; busy stays 0.
REQ-041 rst_n low for 1 cycle after 3 of 10 beats -> m_valid=0 and busy=0 immediately; a new burst with base=0x020, length=2 yields 0x20,0x21 only.
REQ-042 SRAM_STREAMER_STRIDE_EN defined, base=0x000, stride=0x100, length=5 -> addresses 0x000,0x100,0x200,0x300,0x000.

Source files
------------

// File: rtl/sram_streamer.sv
// sram_streamer: reads a burst of SRAM words and emits them on a valid/ready stream.
// Optional macro SRAM_STREAMER_STRIDE_EN adds a stride input; otherwise addresses step by 1.
module sram_streamer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  length,
`ifdef SRAM_STREAMER_STRIDE_EN
    input  logic [ADDR_WIDTH-1:0] stride,
`endif
    output logic                  busy,
    output logic                  done,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    input  logic [DATA_WIDTH-1:0] sram_dout,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready
);

    // state | meaning
    // IDLE  | waiting for start; zero-length requests complete from here
    // RUN   | issuing one read per cycle while the FIFO has room
    // DRAIN | every read issued, emptying the FIFO until the last handshake
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;

    logic [ADDR_WIDTH-1:0]   w_stride;
    logic [ADDR_WIDTH-1:0]   r_stride;
    logic [ADDR_WIDTH-1:0]   r_next_addr;
    logic [ADDR_WIDTH-1:0]   r_sram_addr;
    logic [LEN_WIDTH-1:0]    r_remaining;
    logic                    r_pend;
    logic                    r_done;

    logic [DATA_WIDTH-1:0]   r_fifo [2];
    logic                    r_wr_ptr;
    logic                    r_rd_ptr;
    logic [1:0]              r_count;

    logic                    w_push;
    logic                    w_pop;
    logic                    w_issue;
    logic                    w_load;
    logic                    w_done_set;
    logic [2:0]              w_occupancy;
    logic [2:0]              w_room_limit;

`ifdef SRAM_STREAMER_STRIDE_EN
    assign w_stride = stride;
`else
    assign w_stride = ADDR_WIDTH'(1);
`endif

    assign m_valid      = (r_count != 2'd0);
    assign m_data       = r_fifo[r_rd_ptr];
    assign w_pop        = m_valid & m_ready;
    assign w_push       = r_pend;
    assign w_occupancy  = {1'b0, r_count} + {2'b00, r_pend};
    // A pop this cycle frees a slot in time for the read issued now.
    assign w_room_limit = 3'd2 + {2'b00, w_pop};

    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign sram_we   = 1'b0;
    assign sram_addr = r_sram_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_issue      = 1'b0;
        w_load       = 1'b0;
        w_done_set   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        w_done_set = 1'b1;
                    end else begin
                        w_load       = 1'b1;
                        w_next_state = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (w_occupancy < w_room_limit) begin
                    w_issue = 1'b1;
                    if (r_remaining == LEN_WIDTH'(1)) begin
                        w_next_state = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (w_pop && (r_count == 2'd1) && !r_pend) begin
                    w_next_state = S_IDLE;
                    w_done_set   = 1'b1;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stride    <= '0;
            r_next_addr <= '0;
            r_sram_addr <= '0;
            r_remaining <= '0;
            r_pend      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_done_set;
            r_pend <= w_issue;
            if (w_load) begin
                r_next_addr <= base_addr;
                r_remaining <= length;
                r_stride    <= w_stride;
            end else if (w_issue) begin
                r_sram_addr <= r_next_addr;
                r_next_addr <= r_next_addr + r_stride;
                r_remaining <= r_remaining - LEN_WIDTH'(1);
            end
        end
    end

    // Read data is captured only in the cycle after an issue; the SRAM drives dout continuously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fifo[0] <= '0;
            r_fifo[1] <= '0;
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_count   <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= sram_dout;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_streamer.sv
// Bench for sram_streamer: table vectors, hand-written corner sequences and random bursts,
// with expected beats computed as sram[(base + k*stride) mod 2^ADDR_WIDTH].
`timescale 1ns/1ps
module tb_sram_streamer;
    localparam int DW    = 8;
    localparam int AW    = 10;
    localparam int LW    = 11;
    localparam int DEPTH = 1 << AW;
`ifdef SRAM_STREAMER_STRIDE_EN
    localparam bit STRIDE_ON = 1'b1;
`else
    localparam bit STRIDE_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [LW-1:0] length = '0;
    logic [AW-1:0] cur_stride = AW'(1);
    logic          busy, done, sram_we, m_valid;
    logic          m_ready = 1'b0;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_dout, m_data;

    // Behavioural SRAM: data for the registered address is available in the cycle after the issue.
    logic [DW-1:0] sram [DEPTH];
    assign sram_dout = sram[sram_addr];

    sram_streamer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
`ifdef SRAM_STREAMER_STRIDE_EN
        .stride    (cur_stride),
`endif
        .busy      (busy),
        .done      (done),
        .sram_we   (sram_we),
        .sram_addr (sram_addr),
        .sram_dout (sram_dout),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] base;
        int            len;
        logic [AW-1:0] stride;
        int            mode;
        logic [DW-1:0] exp_first;
        logic [DW-1:0] exp_last;
    } vec_t;

    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    int            rdy_mode = 0;
    int            phase = 0;
    int            busy_n = 0;
    int            we_high_n = 0;
    logic [DW-1:0] got_q[$];
    int            gcyc_q[$];
    int            rise_q[$];
    int            done_q[$];
    logic          prev_stall = 1'b0;
    logic          prev_valid = 1'b0;
    logic [DW-1:0] prev_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [AW-1:0] ref_addr(input logic [AW-1:0] b, input int k,
                                               input logic [AW-1:0] s);
        return AW'(32'(b) + k * 32'(s));
    endfunction

    // One cycle: drive m_ready for the coming edge, then sample what that edge will transfer.
    task automatic step();
        @(negedge clk);
        start = 1'b0;
        cyc++;
        case (rdy_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = ((phase % 3) == 0);
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
        phase++;
        if (rst_n) begin
            if (prev_stall) begin
                check("stall_valid_held", 32'(m_valid), 32'd1);
                check("stall_data_held", 32'(m_data), 32'(prev_data));
            end
            if (m_valid && !prev_valid) rise_q.push_back(cyc);
            if (m_valid && m_ready) begin
                got_q.push_back(m_data);
                gcyc_q.push_back(cyc);
            end
            if (done) done_q.push_back(cyc);
            if (busy) busy_n++;
            if (sram_we !== 1'b0) we_high_n++;
        end
        prev_stall = rst_n && m_valid && !m_ready;
        prev_valid = m_valid;
        prev_data  = m_data;
    endtask

    task automatic pulse_start(input logic [AW-1:0] b, input int l, output int s_cyc);
        start     = 1'b1;
        base_addr = b;
        length    = LW'(l);
        s_cyc     = cyc + 1;
    endtask

    task automatic wait_done(input int d0, input int budget);
        int n = 0;
        while (done_q.size() <= d0 && n < budget) begin
            step();
            n++;
        end
        check("done_within_budget", 32'(done_q.size() > d0), 32'd1);
    endtask

    task automatic run_burst(input logic [AW-1:0] b, input int l, input int mode,
                             output logic [DW-1:0] first, output logic [DW-1:0] last);
        int g0 = got_q.size();
        int d0 = done_q.size();
        int r0 = rise_q.size();
        int b0 = busy_n;
        int s;
        rdy_mode = mode;
        phase    = 0;
        pulse_start(b, l, s);
        wait_done(d0, 100 + 8 * l);
        repeat (3) step();
        check("beat_count", got_q.size() - g0, l);
        for (int k = 0; k < l && (g0 + k) < got_q.size(); k++)
            check("beat_data", 32'(got_q[g0 + k]), 32'(sram[ref_addr(b, k, cur_stride)]));
        check("done_pulses", done_q.size() - d0, 1);
        if (l == 0) begin
            check("len0_done_cycle", (done_q.size() > d0) ? done_q[d0] : -1, s);
            check("len0_busy_cycles", busy_n - b0, 0);
            check("len0_valid_rises", rise_q.size() - r0, 0);
        end else begin
            check("first_valid_cycle", (rise_q.size() > r0) ? rise_q[r0] : -1, s + 2);
            if (got_q.size() > g0 && done_q.size() > d0)
                check("done_after_last_beat", done_q[d0] - gcyc_q[gcyc_q.size() - 1], 1);
            if (mode == 0 && got_q.size() - g0 == l)
                check("one_beat_per_cycle", gcyc_q[gcyc_q.size() - 1] - gcyc_q[g0], l - 1);
        end
        first = (got_q.size() > g0) ? got_q[g0] : 'x;
        last  = (got_q.size() > g0) ? got_q[got_q.size() - 1] : 'x;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          vecs[7];
        logic [DW-1:0] f, l;
        int            g0, g1, d0, r0, s1, s2, n;

        vecs[0] = '{10'h010, 4, 10'h001, 0, 8'h10, 8'h13};
        vecs[1] = '{10'h3FE, 4, 10'h001, 0, 8'hFE, 8'h01};
        vecs[2] = '{10'h040, 8, 10'h001, 1, 8'h40, 8'h47};
        vecs[3] = '{10'h055, 0, 10'h001, 0, 8'h00, 8'h00};
        vecs[4] = '{10'h3FF, 1, 10'h001, 0, 8'hFF, 8'hFF};
        vecs[5] = '{10'h100, 3, 10'h001, 2, 8'h00, 8'h02};
        vecs[6] = '{10'h0F0, 2, 10'h001, 1, 8'hF0, 8'hF1};

        for (int i = 0; i < DEPTH; i++) sram[i] = DW'(i);

        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_m_valid", 32'(m_valid), 32'd0);
        check("reset_sram_we", 32'(sram_we), 32'd0);
        check("reset_sram_addr", 32'(sram_addr), 32'd0);
        check("reset_m_data", 32'(m_data), 32'd0);
        rst_n = 1'b1;
        repeat (2) step();

        for (int i = 0; i < 7; i++) begin
            cur_stride = STRIDE_ON ? vecs[i].stride : AW'(1);
            run_burst(vecs[i].base, vecs[i].len, vecs[i].mode, f, l);
            if (vecs[i].len > 0) begin
                check("vec_first_beat", 32'(f), 32'(vecs[i].exp_first));
                check("vec_last_beat", 32'(l), 32'(vecs[i].exp_last));
            end
        end
        cur_stride = AW'(1);

        // start while busy is ignored
        g0 = got_q.size(); d0 = done_q.size(); rdy_mode = 0;
        pulse_start(10'h200, 6, s1);
        step(); step();
        start = 1'b1; base_addr = 10'h300; length = LW'(5);
        wait_done(d0, 100);
        repeat (3) step();
        check("busy_start_beat_count", got_q.size() - g0, 6);
        for (int k = 0; k < 6 && (g0 + k) < got_q.size(); k++)
            check("busy_start_data", 32'(got_q[g0 + k]), 32'(sram[ref_addr(10'h200, k, 10'h001)]));
        check("busy_start_done_pulses", done_q.size() - d0, 1);

        // start during the done cycle is accepted
        g0 = got_q.size(); d0 = done_q.size(); r0 = rise_q.size(); rdy_mode = 2;
        pulse_start(10'h080, 3, s1);
        wait_done(d0, 100);
        pulse_start(10'h090, 2, s2);
        wait_done(d0 + 1, 100);
        repeat (3) step();
        check("restart_beat_count", got_q.size() - g0, 5);
        for (int k = 0; k < 5 && (g0 + k) < got_q.size(); k++)
            check("restart_data", 32'(got_q[g0 + k]),
                  32'(sram[(k < 3) ? ref_addr(10'h080, k, 10'h001) : ref_addr(10'h090, k - 3, 10'h001)]));
        check("restart_first_valid", (rise_q.size() > r0 + 1) ? rise_q[r0 + 1] : -1, s2 + 2);
        check("restart_done_pulses", done_q.size() - d0, 2);

        // reset in the middle of a 10-beat burst
        g0 = got_q.size(); d0 = done_q.size(); rdy_mode = 0; n = 0;
        pulse_start(10'h000, 10, s1);
        while (got_q.size() - g0 < 3 && n < 50) begin
            step();
            n++;
        end
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midreset_beats_before", got_q.size() - g0, 3);
        check("midreset_m_valid", 32'(m_valid), 32'd0);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_done", 32'(done), 32'd0);
        check("midreset_sram_addr", 32'(sram_addr), 32'd0);
        check("midreset_m_data", 32'(m_data), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        g1 = got_q.size();
        repeat (4) step();
        check("midreset_no_stale_beats", got_q.size() - g1, 0);
        check("midreset_no_done", done_q.size() - d0, 0);
        run_burst(10'h020, 2, 0, f, l);
        check("post_reset_first", 32'(f), 32'h20);
        check("post_reset_last", 32'(l), 32'h21);

`ifdef SRAM_STREAMER_STRIDE_EN
        for (int i = 0; i < DEPTH; i++) sram[i] = DW'($urandom);
        cur_stride = 10'h100;
        g0 = got_q.size();
        run_burst(10'h000, 5, 1, f, l);
        for (int k = 0; k < 5 && (g0 + k) < got_q.size(); k++)
            check("stride_fixed_addr", 32'(got_q[g0 + k]), 32'(sram[10'h100 * (k % 4)]));
        cur_stride = 10'h000;
        g0 = got_q.size();
        run_burst(10'h155, 3, 2, f, l);
        for (int k = 0; k < 3 && (g0 + k) < got_q.size(); k++)
            check("stride_zero_repeat", 32'(got_q[g0 + k]), 32'(sram[10'h155]));
        cur_stride = AW'(1);
`endif

        for (int t = 0; t < 15; t++) begin
            for (int i = 0; i < DEPTH; i++) sram[i] = DW'($urandom);
            cur_stride = STRIDE_ON ? AW'($urandom) : AW'(1);
            run_burst(AW'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 12)),
                      int'($urandom_range(0, 2)), f, l);
        end

        check("sram_we_never_high", we_high_n, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
